// File: rtl/sw_cfg_ctrl_if.sv
// Host-side register bus for sw_cfg_ctrl: word writes into the shadow register
// and the commit request that arms it for the next frame boundary.
interface sw_cfg_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4
);
    localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              commit_valid;
    logic              commit_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit_valid,
        input  wr_ready,
        input  commit_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit_valid,
        output wr_ready,
        output commit_ready
    );
endinterface

// File: rtl/sw_cfg_ctrl.sv
// Crossbar switch-vector sequencer: stages a new pattern in a shadow register and
// swaps it onto sw only at a frame boundary, then blanks the output while it settles.
module sw_cfg_ctrl #(
    parameter int              SW_W      = 128,
    parameter int              WORD_W    = 32,
    parameter int              NWORDS    = 4,
    parameter int              FRAME_LEN = 196,
    parameter int              SETTLE    = 2,
    parameter logic [SW_W-1:0] SW_RST    = '0
) (
    input  logic             clk,
    input  logic             rst,
    sw_cfg_ctrl_if.slave     bus,
    input  logic             sync_in,
    output logic [SW_W-1:0]  sw,
    output logic             sw_update,
    output logic             blank,
    output logic             armed,
    output logic             err_incomplete
);
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]        state;
    logic [FW-1:0]     fcnt;
    logic [3:0]        scnt;
    logic [NWORDS-1:0] mask;
    logic [SW_W-1:0]   shadow;
    logic              boundary;
    logic              wr_fire;
    logic              cm_fire;
    logic              frame_end;

    assign frame_end = (fcnt == FW'(FRAME_LEN - 1));
    assign boundary  = frame_end || sync_in;
    assign wr_fire   = bus.wr_valid && (state == ST_IDLE);
    assign cm_fire   = bus.commit_valid && (state == ST_IDLE);

    // Handshake and status flags decode the state register only, so no input
    // reaches an output without passing through a flop.
    assign bus.wr_ready     = (state == ST_IDLE);
    assign bus.commit_ready = (state == ST_IDLE);
    assign armed            = (state == ST_ARMED);
    assign blank            = (state == ST_SETTLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if (sync_in || frame_end) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_fire) begin
            shadow[int'(bus.wr_addr)*WORD_W +: WORD_W] <= bus.wr_data;
        end
    end

    // Writes are only accepted in IDLE, so they never collide with the clear on apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else if ((state == ST_ARMED) && boundary) begin
            mask <= '0;
        end else if (wr_fire) begin
            mask[bus.wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            scnt           <= '0;
            sw             <= SW_RST;
            sw_update      <= 1'b0;
            err_incomplete <= 1'b0;
        end else begin
            sw_update      <= 1'b0;
            err_incomplete <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The mask is sampled before any same-cycle write lands.
                    if (cm_fire) begin
                        if (mask == {NWORDS{1'b1}}) begin
                            state <= ST_ARMED;
                        end else begin
                            err_incomplete <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (boundary) begin
                        sw        <= shadow;
                        sw_update <= 1'b1;
                        scnt      <= 4'(SETTLE);
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (scnt <= 4'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sw_cfg_ctrl.sv
// Scoreboard bench for sw_cfg_ctrl: directed scenarios followed by random traffic,
// with a frame/commit reference model and a monitor that checks every output pulse.
module tb_sw_cfg_ctrl;
    localparam int           SW_W      = 128;
    localparam int           WORD_W    = 32;
    localparam int           NWORDS    = 4;
    localparam int           FRAME_LEN = 196;
    localparam int           SETTLE    = 2;
    localparam logic [127:0] SW_RST    = '0;

    typedef struct {
        bit           is_err;
        int           cyc;
        logic [127:0] sw;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync_in;
    logic [127:0] sw;
    logic         sw_update;
    logic         blank;
    logic         armed;
    logic         err_incomplete;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    ev_t          sbq[$];

    logic [31:0]  m_shadow [4];
    logic [3:0]   m_mask;
    logic [127:0] m_sw;
    int           m_fcnt;

    sw_cfg_ctrl_if #(.WORD_W(WORD_W), .NWORDS(NWORDS)) bus ();

    sw_cfg_ctrl #(
        .SW_W(SW_W), .WORD_W(WORD_W), .NWORDS(NWORDS),
        .FRAME_LEN(FRAME_LEN), .SETTLE(SETTLE), .SW_RST(SW_RST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sync_in(sync_in),
        .sw(sw),
        .sw_update(sw_update),
        .blank(blank),
        .armed(armed),
        .err_incomplete(err_incomplete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Frame position seen by the host: resets on sync or at the end of each frame.
    always @(posedge clk or posedge rst) begin
        if (rst) m_fcnt = 0;
        else if (sync_in || m_fcnt == FRAME_LEN - 1) m_fcnt = 0;
        else m_fcnt = m_fcnt + 1;
    end

    function automatic logic [127:0] packShadow();
        return {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.wr_valid     = 1'b0;
        bus.wr_addr      = 2'd0;
        bus.wr_data      = 32'd0;
        bus.commit_valid = 1'b0;
        sync_in          = 1'b0;
    endtask

    task automatic waitFcnt(input int target);
        int n;
        n = 0;
        while (m_fcnt != target && n < 2 * FRAME_LEN) begin
            step();
            n++;
        end
    endtask

    // Monitor: every sw_update / err_incomplete pulse must match the oldest expectation.
    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b0) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_event: got nothing at cycle %0d expected %s", e.cyc,
                         e.is_err ? "err_incomplete" : "sw_update");
            end
            if (sw_update === 1'b1 || err_incomplete === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got upd=%0b err=%0b at cycle %0d expected none",
                             sw_update, err_incomplete, cyc);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("ev_err_pulse", 128'(err_incomplete), 128'(e.is_err));
                    checkOutput("ev_upd_pulse", 128'(sw_update), 128'(!e.is_err));
                    checkOutput("ev_cycle", 128'(cyc), 128'(e.cyc));
                    checkOutput("ev_sw", sw, e.sw);
                end
            end
        end
    end

    // One IDLE-cycle host operation; an accepted commit is followed through ARMED and SETTLE.
    task automatic applyStimulus(input bit do_wr, input logic [1:0] a, input logic [31:0] d,
                                 input bit do_cm, input int sync_at, input bit rnd, input bit rst_mid);
        bit  accepted;
        bit  bnd;
        bit  sy;
        int  n;
        ev_t e;
        bus.wr_valid     = do_wr;
        bus.wr_addr      = a;
        bus.wr_data      = d;
        bus.commit_valid = do_cm;
        sync_in          = rnd && ($urandom_range(0, 49) == 0);
        @(negedge clk);
        checkOutput("idle_wr_ready", 128'(bus.wr_ready), 128'(1));
        checkOutput("idle_commit_ready", 128'(bus.commit_ready), 128'(1));
        checkOutput("idle_armed", 128'(armed), 128'(0));
        accepted = do_cm && (m_mask == 4'hF);
        if (do_cm && !accepted) begin
            e.is_err = 1'b1;
            e.cyc    = cyc + 1;
            e.sw     = m_sw;
            sbq.push_back(e);
        end
        if (do_wr) begin
            m_shadow[a] = d;
            m_mask[a]   = 1'b1;
        end
        step();
        clearInputs();
        if (!accepted) return;

        n   = 0;
        bnd = 1'b0;
        while (!bnd && n < 2 * FRAME_LEN + 4) begin
            sy  = (sync_at >= 0 && m_fcnt == sync_at) || (rnd && $urandom_range(0, 99) == 0);
            bnd = sy || (m_fcnt == FRAME_LEN - 1);
            sync_in          = sy;
            bus.wr_valid     = 1'($urandom_range(0, 1));
            bus.wr_addr      = 2'($urandom);
            bus.wr_data      = $urandom;
            bus.commit_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("armed_flag", 128'(armed), 128'(1));
            checkOutput("armed_wr_ready", 128'(bus.wr_ready), 128'(0));
            checkOutput("armed_commit_ready", 128'(bus.commit_ready), 128'(0));
            checkOutput("armed_sw_hold", sw, m_sw);
            if (bnd) begin
                e.is_err = 1'b0;
                e.cyc    = cyc + 1;
                e.sw     = packShadow();
                sbq.push_back(e);
                m_sw   = packShadow();
                m_mask = 4'h0;
            end
            step();
            n++;
        end
        clearInputs();
        if (!bnd) begin
            checks++;
            errors++;
            $display("[TB] FAIL armed_timeout: got no boundary in %0d cycles expected one", n);
            return;
        end

        for (int i = 1; i <= SETTLE; i++) begin
            if (rnd) sync_in = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            if (rst_mid && i == 1) begin
                #1 rst = 1'b1;
                #1;
                checkOutput("rst_mid_sw", sw, SW_RST);
                checkOutput("rst_mid_blank", 128'(blank), 128'(0));
                checkOutput("rst_mid_armed", 128'(armed), 128'(0));
                checkOutput("rst_mid_wr_ready", 128'(bus.wr_ready), 128'(1));
                checkOutput("rst_mid_commit_ready", 128'(bus.commit_ready), 128'(1));
                m_sw   = SW_RST;
                m_mask = 4'h0;
                sync_in = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            checkOutput("settle_blank", 128'(blank), 128'(1));
            checkOutput("settle_wr_ready", 128'(bus.wr_ready), 128'(0));
            step();
        end
        sync_in = 1'b0;
        @(negedge clk);
        checkOutput("post_blank", 128'(blank), 128'(0));
        checkOutput("post_wr_ready", 128'(bus.wr_ready), 128'(1));
        checkOutput("post_armed", 128'(armed), 128'(0));
        checkOutput("post_sw", sw, m_sw);
        step();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish expected completion by 3 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] pattern1;
        pattern1 = 128'h44444444_33333333_22222222_11111111;
        rst = 1'b1;
        clearInputs();
        m_mask = 4'h0;
        m_sw   = SW_RST;
        for (int i = 0; i < 4; i++) m_shadow[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_sw", sw, SW_RST);
        checkOutput("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
        checkOutput("rst_commit_ready", 128'(bus.commit_ready), 128'(1));
        checkOutput("rst_sw_update", 128'(sw_update), 128'(0));
        checkOutput("rst_blank", 128'(blank), 128'(0));
        checkOutput("rst_armed", 128'(armed), 128'(0));
        checkOutput("rst_err", 128'(err_incomplete), 128'(0));
        step();
        rst = 1'b0;

        $display("[TB] full pattern, commit at fcnt 10");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 32'h11111111 * (i + 1), 1'b0, -1, 1'b0, 1'b0);
        waitFcnt(10);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t1_sw_value", sw, pattern1);

        $display("[TB] incomplete commit, then write+commit in one cycle");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'(i), 32'hA0A0A0A0 + i, 1'b0, -1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t2_sw_unchanged", sw, pattern1);
        applyStimulus(1'b1, 2'd3, 32'hA3A3A3A3, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t3_sw_unchanged", sw, pattern1);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t3_sw_value", sw, 128'hA3A3A3A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);

        $display("[TB] commit on the frame-end cycle");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 32'hB0000000 + i, 1'b0, -1, 1'b0, 1'b0);
        waitFcnt(FRAME_LEN - 1);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t4_sw_value", sw, 128'hB0000003_B0000002_B0000001_B0000000);

        $display("[TB] sync_in while armed, junk writes ignored");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 32'hC0DE0000 + i, 1'b0, -1, 1'b0, 1'b0);
        waitFcnt(20);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 50, 1'b0, 1'b0);
        checkOutput("t5_sw_value", sw, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);

        $display("[TB] reset during settle");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 32'hD0000000 + i, 1'b0, -1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b0, 1'b0);
        checkOutput("t6_sw_after_rst", sw, SW_RST);

        $display("[TB] random traffic");
        repeat (60) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0, 1: applyStimulus(1'b1, 2'($urandom), $urandom, 1'b0, -1, 1'b1, 1'b0);
                2:    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, -1, 1'b1, 1'b0);
                3:    applyStimulus(1'b1, 2'($urandom), $urandom, 1'b1, -1, 1'b1, 1'b0);
                default: applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, -1, 1'b1, 1'b0);
            endcase
        end

        repeat (3) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending events expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
